// File: rtl/dcache_mshr_file.sv
// Miss status holding register file for a data cache: tracks outstanding misses,
// merges secondary GETs, issues bus requests in allocation order and drives fills.
module dcache_mshr_file #(
    parameter int unsigned MSHR_DEPTH = 4,
    parameter int unsigned TAG_W      = 10,
    parameter int unsigned IDX_W      = 5,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ID_W       = $clog2(MSHR_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en_i,
    input  logic [TAG_W-1:0]  alloc_tag_i,
    input  logic [IDX_W-1:0]  alloc_idx_i,
    input  logic [DATA_W-1:0] alloc_data_i,
    input  logic [1:0]        alloc_msg_i,
    output logic              alloc_ack_o,
    input  logic [TAG_W-1:0]  lookup_tag_i,
    input  logic [IDX_W-1:0]  lookup_idx_i,
    output logic              lookup_hit_o,
    output logic [DATA_W-1:0] lookup_data_o,
    output logic [1:0]        lookup_msg_o,
    output logic              req_vld_o,
    output logic [TAG_W-1:0]  req_tag_o,
    output logic [IDX_W-1:0]  req_idx_o,
    output logic [DATA_W-1:0] req_data_o,
    output logic [1:0]        req_msg_o,
    output logic [ID_W-1:0]   req_id_o,
    input  logic              req_ack_i,
    input  logic              rsp_vld_i,
    input  logic [ID_W-1:0]   rsp_id_i,
    input  logic [DATA_W-1:0] rsp_data_i,
    output logic              fill_en_o,
    output logic [TAG_W-1:0]  fill_tag_o,
    output logic [IDX_W-1:0]  fill_idx_o,
    output logic [DATA_W-1:0] fill_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ID_W:0]     cnt_o,
    output logic              proto_err_o
);

    localparam int unsigned CNT_W = ID_W + 1;
    localparam logic [1:0] MSG_NONE  = 2'd0;
    localparam logic [1:0] MSG_GET_S = 2'd1;
    localparam logic [1:0] MSG_GET_M = 2'd2;
    localparam logic [1:0] MSG_PUT_M = 2'd3;

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_WAIT_ISS = 2'd1,
        ST_WAIT_RSP = 2'd2
    } ent_st_e;

    ent_st_e           st_q   [MSHR_DEPTH];
    ent_st_e           st_d   [MSHR_DEPTH];
    logic [TAG_W-1:0]  tag_q  [MSHR_DEPTH];
    logic [TAG_W-1:0]  tag_d  [MSHR_DEPTH];
    logic [IDX_W-1:0]  idx_q  [MSHR_DEPTH];
    logic [IDX_W-1:0]  idx_d  [MSHR_DEPTH];
    logic [DATA_W-1:0] data_q [MSHR_DEPTH];
    logic [DATA_W-1:0] data_d [MSHR_DEPTH];
    logic [1:0]        msg_q  [MSHR_DEPTH];
    logic [1:0]        msg_d  [MSHR_DEPTH];
    logic [ID_W-1:0]   fifo_q [MSHR_DEPTH];
    logic [ID_W-1:0]   fifo_d [MSHR_DEPTH];

    logic [ID_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d, cnt_q, cnt_d;
    logic             proto_err_q, proto_err_d;

    logic            match_any, free_any;
    logic [ID_W-1:0] match_id, free_id, head_id;
    logic            issue, head_put, alloc_get, alloc_try, match_busy;
    logic            merge_ok, merge_upd, new_alloc, rsp_hit;

    // Address CAM for merge candidates and lowest free entry search
    always_comb begin
        match_any = 1'b0;
        match_id  = '0;
        free_any  = 1'b0;
        free_id   = '0;
        for (int unsigned i = 0; i < MSHR_DEPTH; i++) begin
            if (!match_any && st_q[i] != ST_FREE &&
                (msg_q[i] == MSG_GET_S || msg_q[i] == MSG_GET_M) &&
                tag_q[i] == alloc_tag_i && idx_q[i] == alloc_idx_i) begin
                match_any = 1'b1;
                match_id  = ID_W'(i);
            end
            if (!free_any && st_q[i] == ST_FREE) begin
                free_any = 1'b1;
                free_id  = ID_W'(i);
            end
        end
    end

    // Probe port: only write-intent entries can forward data
    always_comb begin
        lookup_hit_o  = 1'b0;
        lookup_data_o = '0;
        lookup_msg_o  = MSG_NONE;
        for (int unsigned i = 0; i < MSHR_DEPTH; i++) begin
            if (!lookup_hit_o && st_q[i] != ST_FREE && msg_q[i] == MSG_GET_M &&
                tag_q[i] == lookup_tag_i && idx_q[i] == lookup_idx_i) begin
                lookup_hit_o  = 1'b1;
                lookup_data_o = data_q[i];
                lookup_msg_o  = msg_q[i];
            end
        end
    end

    assign head_id    = fifo_q[rd_ptr_q];
    assign req_vld_o  = (fifo_cnt_q != '0);
    assign req_tag_o  = tag_q[head_id];
    assign req_idx_o  = idx_q[head_id];
    assign req_data_o = data_q[head_id];
    assign req_msg_o  = msg_q[head_id];
    assign req_id_o   = head_id;
    assign issue      = req_vld_o && req_ack_i;
    assign head_put   = (msg_q[head_id] == MSG_PUT_M);

    // An entry being accepted by the bus this cycle already counts as waiting for data
    assign alloc_get  = (alloc_msg_i == MSG_GET_S) || (alloc_msg_i == MSG_GET_M);
    assign alloc_try  = rst && alloc_en_i && !full_o && (alloc_msg_i != MSG_NONE);
    assign match_busy = (st_q[match_id] == ST_WAIT_RSP) || (issue && head_id == match_id);
    assign merge_ok   = alloc_try && alloc_get && match_any &&
                        !(alloc_msg_i == MSG_GET_M && match_busy && msg_q[match_id] == MSG_GET_S);
    assign merge_upd  = merge_ok && (alloc_msg_i == MSG_GET_M) && !match_busy;
    assign new_alloc  = alloc_try && !(alloc_get && match_any) && free_any;
    assign alloc_ack_o = merge_ok || new_alloc;

    assign rsp_hit     = rsp_vld_i && (st_q[rsp_id_i] == ST_WAIT_RSP);
    assign fill_en_o   = rsp_hit;
    assign fill_tag_o  = rsp_hit ? tag_q[rsp_id_i] : '0;
    assign fill_idx_o  = rsp_hit ? idx_q[rsp_id_i] : '0;
    assign fill_data_o = rsp_hit ? rsp_data_i : '0;

    assign cnt_o       = cnt_q;
    assign empty_o     = (cnt_q == '0);
    assign full_o      = (cnt_q == CNT_W'(MSHR_DEPTH));
    assign proto_err_o = proto_err_q;

    // Next-state for entries, issue FIFO and status counters
    always_comb begin
        st_d        = st_q;
        tag_d       = tag_q;
        idx_d       = idx_q;
        data_d      = data_q;
        msg_d       = msg_q;
        fifo_d      = fifo_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        proto_err_d = proto_err_q;
        cnt_d       = cnt_q + CNT_W'(new_alloc) - CNT_W'(rsp_hit) - CNT_W'(issue && head_put);

        if (issue) begin
            st_d[head_id] = head_put ? ST_FREE : ST_WAIT_RSP;
            rd_ptr_d      = rd_ptr_q + ID_W'(1);
        end
        if (rsp_hit) begin
            st_d[rsp_id_i] = ST_FREE;
        end else if (rsp_vld_i) begin
            proto_err_d = 1'b1;
        end
        if (merge_upd) begin
            data_d[match_id] = alloc_data_i;
            msg_d[match_id]  = MSG_GET_M;
        end
        if (new_alloc) begin
            st_d[free_id]    = ST_WAIT_ISS;
            tag_d[free_id]   = alloc_tag_i;
            idx_d[free_id]   = alloc_idx_i;
            data_d[free_id]  = alloc_data_i;
            msg_d[free_id]   = alloc_msg_i;
            fifo_d[wr_ptr_q] = free_id;
            wr_ptr_d         = wr_ptr_q + ID_W'(1);
        end
        fifo_cnt_d = fifo_cnt_q + CNT_W'(new_alloc) - CNT_W'(issue);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MSHR_DEPTH; i++) begin
                st_q[i]   <= ST_FREE;
                tag_q[i]  <= '0;
                idx_q[i]  <= '0;
                data_q[i] <= '0;
                msg_q[i]  <= MSG_NONE;
                fifo_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            tag_q       <= tag_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            msg_q       <= msg_d;
            fifo_q      <= fifo_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_dcache_mshr_file.sv
// Randomized bench for dcache_mshr_file against an entry/queue reference model.
module tb_dcache_mshr_file;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_en_i = 1'b0;
    logic [9:0]  alloc_tag_i = '0;
    logic [4:0]  alloc_idx_i = '0;
    logic [63:0] alloc_data_i = '0;
    logic [1:0]  alloc_msg_i = '0;
    logic        alloc_ack_o;
    logic [9:0]  lookup_tag_i = '0;
    logic [4:0]  lookup_idx_i = '0;
    logic        lookup_hit_o;
    logic [63:0] lookup_data_o;
    logic [1:0]  lookup_msg_o;
    logic        req_vld_o;
    logic [9:0]  req_tag_o;
    logic [4:0]  req_idx_o;
    logic [63:0] req_data_o;
    logic [1:0]  req_msg_o;
    logic [1:0]  req_id_o;
    logic        req_ack_i = 1'b0;
    logic        rsp_vld_i = 1'b0;
    logic [1:0]  rsp_id_i = '0;
    logic [63:0] rsp_data_i = '0;
    logic        fill_en_o;
    logic [9:0]  fill_tag_o;
    logic [4:0]  fill_idx_o;
    logic [63:0] fill_data_o;
    logic        full_o, empty_o, proto_err_o;
    logic [2:0]  cnt_o;

    dcache_mshr_file dut (
        .clk(clk), .rst(rst),
        .alloc_en_i(alloc_en_i), .alloc_tag_i(alloc_tag_i), .alloc_idx_i(alloc_idx_i),
        .alloc_data_i(alloc_data_i), .alloc_msg_i(alloc_msg_i), .alloc_ack_o(alloc_ack_o),
        .lookup_tag_i(lookup_tag_i), .lookup_idx_i(lookup_idx_i), .lookup_hit_o(lookup_hit_o),
        .lookup_data_o(lookup_data_o), .lookup_msg_o(lookup_msg_o),
        .req_vld_o(req_vld_o), .req_tag_o(req_tag_o), .req_idx_o(req_idx_o),
        .req_data_o(req_data_o), .req_msg_o(req_msg_o), .req_id_o(req_id_o), .req_ack_i(req_ack_i),
        .rsp_vld_i(rsp_vld_i), .rsp_id_i(rsp_id_i), .rsp_data_i(rsp_data_i),
        .fill_en_o(fill_en_o), .fill_tag_o(fill_tag_o), .fill_idx_o(fill_idx_o),
        .fill_data_o(fill_data_o), .full_o(full_o), .empty_o(empty_o), .cnt_o(cnt_o),
        .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: per-entry status (0 free, 1 waiting issue, 2 waiting data) and issue queue
    int          m_st   [DEPTH];
    logic [9:0]  m_tag  [DEPTH];
    logic [4:0]  m_idx  [DEPTH];
    logic [63:0] m_data [DEPTH];
    int          m_msg  [DEPTH];
    int          m_q[$];
    bit          m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_st[i] = 0; m_msg[i] = 0; m_tag[i] = '0; m_idx[i] = '0; m_data[i] = '0;
        end
        m_q.delete();
        m_err = 1'b0;
    endtask

    task automatic idle();
        alloc_en_i = 1'b0; alloc_msg_i = 2'd0; req_ack_i = 1'b0;
        rsp_vld_i = 1'b0; rsp_id_i = '0; rsp_data_i = '0;
    endtask

    // Check one cycle against the model, advance the model, move to the next falling edge
    task automatic step();
        int busy, head, mid, fid, lk;
        bit e_vld, issue, e_ack, do_new, do_upd, in_rsp, rsp_ok;
        if (!rst) model_clear();
        #1;
        busy = 0;
        foreach (m_st[i]) if (m_st[i] != 0) busy++;
        e_vld = (m_q.size() != 0);
        head  = e_vld ? m_q[0] : 0;
        issue = e_vld && req_ack_i;
        e_ack = 0; do_new = 0; do_upd = 0; mid = -1; fid = -1;
        if (rst && alloc_en_i && busy != DEPTH && alloc_msg_i != 0) begin
            if (alloc_msg_i != 3)
                for (int i = 0; i < DEPTH; i++)
                    if (mid < 0 && m_st[i] != 0 && (m_msg[i] == 1 || m_msg[i] == 2) &&
                        m_tag[i] == alloc_tag_i && m_idx[i] == alloc_idx_i) mid = i;
            if (mid >= 0) begin
                in_rsp = (m_st[mid] == 2) || (issue && head == mid);
                if (!(alloc_msg_i == 2 && in_rsp && m_msg[mid] == 1)) begin
                    e_ack = 1;
                    do_upd = (alloc_msg_i == 2) && !in_rsp;
                end
            end else begin
                for (int i = DEPTH - 1; i >= 0; i--) if (m_st[i] == 0) fid = i;
                e_ack = 1; do_new = 1;
            end
        end
        rsp_ok = rst && rsp_vld_i && m_st[rsp_id_i] == 2;
        lk = -1;
        for (int i = 0; i < DEPTH; i++)
            if (lk < 0 && m_st[i] != 0 && m_msg[i] == 2 &&
                m_tag[i] == lookup_tag_i && m_idx[i] == lookup_idx_i) lk = i;

        chk("alloc_ack", alloc_ack_o, e_ack);
        chk("req_vld", req_vld_o, e_vld);
        if (e_vld) begin
            chk("req_id", req_id_o, head);
            chk("req_tag", req_tag_o, m_tag[head]);
            chk("req_idx", req_idx_o, m_idx[head]);
            chk("req_data", req_data_o, m_data[head]);
            chk("req_msg", req_msg_o, m_msg[head]);
        end
        chk("fill_en", fill_en_o, rsp_ok);
        if (rsp_ok) begin
            chk("fill_tag", fill_tag_o, m_tag[rsp_id_i]);
            chk("fill_idx", fill_idx_o, m_idx[rsp_id_i]);
            chk("fill_data", fill_data_o, rsp_data_i);
        end
        chk("lookup_hit", lookup_hit_o, lk >= 0);
        chk("lookup_data", lookup_data_o, (lk >= 0) ? m_data[lk] : 64'd0);
        chk("lookup_msg", lookup_msg_o, (lk >= 0) ? m_msg[lk] : 0);
        chk("cnt", cnt_o, busy);
        chk("empty", empty_o, busy == 0);
        chk("full", full_o, busy == DEPTH);
        chk("proto_err", proto_err_o, m_err);

        if (issue) begin
            m_st[head] = (m_msg[head] == 3) ? 0 : 2;
            void'(m_q.pop_front());
        end
        if (rsp_ok) m_st[rsp_id_i] = 0;
        else if (rst && rsp_vld_i) m_err = 1'b1;
        if (do_upd) begin
            m_data[mid] = alloc_data_i;
            m_msg[mid]  = 2;
        end
        if (do_new) begin
            m_st[fid] = 1; m_tag[fid] = alloc_tag_i; m_idx[fid] = alloc_idx_i;
            m_data[fid] = alloc_data_i; m_msg[fid] = alloc_msg_i;
            m_q.push_back(fid);
        end
        @(negedge clk);
    endtask

    task automatic alloc(input logic [1:0] msg, input logic [9:0] tag, input logic [4:0] idx,
                         input logic [63:0] data);
        alloc_en_i = 1'b1; alloc_msg_i = msg; alloc_tag_i = tag;
        alloc_idx_i = idx; alloc_data_i = data;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        int wr[$];
        model_clear();
        @(negedge clk);
        alloc(2'd1, 10'h12, 5'd3, 64'h0);
        do_reset();

        // Single GET_S miss end to end
        alloc(2'd1, 10'h12, 5'd3, 64'h0);
        #1 chk("d_first_ack", alloc_ack_o, 1'b1);
        step();
        idle();
        #1 chk("d_first_req_msg", req_msg_o, 2'd1);
        step();
        req_ack_i = 1'b1; step();
        idle(); rsp_vld_i = 1'b1; rsp_id_i = 2'd0; rsp_data_i = 64'hAB;
        #1 chk("d_fill_tag", fill_tag_o, 10'h12);
        chk("d_fill_data", fill_data_o, 64'hAB);
        step();
        idle();
        #1 chk("d_empty", empty_o, 1'b1);
        step();

        // GET_M merge overwrites pending store data
        alloc(2'd2, 10'h5, 5'd0, 64'd1); step();
        alloc(2'd2, 10'h5, 5'd0, 64'd2); step();
        idle(); lookup_tag_i = 10'h5; lookup_idx_i = 5'd0;
        #1 chk("d_merge_cnt", cnt_o, 3'd1);
        chk("d_merge_req_data", req_data_o, 64'd2);
        chk("d_merge_lookup", lookup_data_o, 64'd2);
        step();
        req_ack_i = 1'b1; step();
        idle(); rsp_vld_i = 1'b1; rsp_id_i = 2'd0; step();

        // Response to a free entry
        idle(); rsp_vld_i = 1'b1; rsp_id_i = 2'd2;
        #1 chk("d_stale_fill", fill_en_o, 1'b0);
        step();
        idle();
        #1 chk("d_proto_err", proto_err_o, 1'b1);
        step();
        do_reset();

        // Fill to capacity with the bus stalled
        for (int i = 1; i <= DEPTH; i++) begin
            alloc(2'd1, 10'(i), 5'd1, 64'(i)); step();
        end
        alloc(2'd1, 10'h3F, 5'd1, 64'h9);
        #1 chk("d_full", full_o, 1'b1);
        chk("d_full_refuse", alloc_ack_o, 1'b0);
        step();
        idle();
        for (int i = 0; i < 10; i++) step();
        do_reset();

        // Writeback ahead of a read in allocation order
        alloc(2'd3, 10'h7, 5'd2, 64'h77); step();
        alloc(2'd1, 10'h8, 5'd2, 64'h0); step();
        idle(); req_ack_i = 1'b1;
        #1 chk("d_put_first", req_msg_o, 2'd3);
        step();
        #1 chk("d_get_next", req_msg_o, 2'd1);
        chk("d_put_no_fill", fill_en_o, 1'b0);
        step();
        idle();
        step();

        // Random traffic with occasional resets mid-transaction
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            alloc_en_i   = ($urandom_range(0, 9) < 6);
            alloc_msg_i  = 2'($urandom_range(1, 3));
            alloc_tag_i  = 10'($urandom_range(0, 3));
            alloc_idx_i  = 5'($urandom_range(0, 1));
            alloc_data_i = {$urandom, $urandom};
            lookup_tag_i = 10'($urandom_range(0, 3));
            lookup_idx_i = 5'($urandom_range(0, 1));
            req_ack_i    = $urandom_range(0, 1);
            wr.delete();
            for (int i = 0; i < DEPTH; i++) if (m_st[i] == 2) wr.push_back(i);
            rsp_vld_i  = ($urandom_range(0, 9) < 5);
            if (wr.size() != 0 && $urandom_range(0, 19) != 0)
                rsp_id_i = 2'(wr[$urandom_range(0, wr.size() - 1)]);
            else
                rsp_id_i = 2'($urandom_range(0, DEPTH - 1));
            rsp_data_i = {$urandom, $urandom};
            step();
        end
        rst = 1'b1;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
